pc_sequencer: RTL

- Parametrised program-counter unit for the fetch stage. Replaces a bare PC register.
- Holds the fetch address and produces the next PC itself: sequential increment, branch redirect, stall hold, halt/resume.
- Presents the address to instruction fetch with a valid/ready handshake.
- Keeps the previous PC for the decode stage, plus sticky misalignment and redirect-count status.

---
 rtl/pc_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter: increment, branch redirect, stall, halt/resume, fetch handshake
// Optional feature macro: PC_LIMIT_WRAP_EN (sequential fetch wraps to RESET_VECTOR at PC_LIMIT)
module pc_sequencer #(
    parameter int unsigned          PC_WIDTH     = 64,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int unsigned          INSTR_BYTES  = 4,
    parameter int unsigned          CNT_WIDTH    = 16,
    parameter int unsigned          PC_LIMIT     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 fetch_ready,
    input  logic                 branch_taken,
    input  logic [PC_WIDTH-1:0]  branch_target,
    input  logic                 halt_req,
    input  logic                 resume,
    output logic [PC_WIDTH-1:0]  pc_out,
    output logic                 pc_valid,
    output logic [PC_WIDTH-1:0]  pc_seq,
    output logic [PC_WIDTH-1:0]  pc_prev,
    output logic                 halted,
    output logic                 misalign_err,
    output logic [CNT_WIDTH-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

`ifdef PC_LIMIT_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [PC_WIDTH-1:0] STEP      = PC_WIDTH'(INSTR_BYTES);
    localparam logic [PC_WIDTH-1:0] LOW_MASK  = PC_WIDTH'(INSTR_BYTES - 1);
    localparam logic [PC_WIDTH-1:0] LIMIT_VAL = PC_WIDTH'(PC_LIMIT);

    state_t                 state;
    logic [PC_WIDTH-1:0]    next_seq;
    logic [PC_WIDTH-1:0]    aligned_target;
    logic                   target_misaligned;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic                   take_branch;

    assign pc_seq = pc_out + STEP;

    always_comb begin
        next_seq          = pc_seq;
        // WRAP_EN folds to a constant, so the limit compare vanishes in the default build
        if (WRAP_EN && (pc_seq >= LIMIT_VAL)) begin
            next_seq = RESET_VECTOR;
        end
        aligned_target    = branch_target & ~LOW_MASK;
        target_misaligned = |(branch_target & LOW_MASK);
        cnt_next          = (&redirect_cnt) ? redirect_cnt : redirect_cnt + CNT_WIDTH'(1);
        take_branch       = branch_taken && (state != ST_BOOT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_BOOT;
            pc_out       <= RESET_VECTOR;
            pc_prev      <= '0;
            pc_valid     <= 1'b0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
            redirect_cnt <= '0;
        end else if (take_branch) begin
            // a redirect cancels any pending fetch and leaves HALT as well
            state        <= ST_RUN;
            pc_out       <= aligned_target;
            pc_prev      <= pc_out;
            pc_valid     <= 1'b1;
            halted       <= 1'b0;
            redirect_cnt <= cnt_next;
            if (target_misaligned) begin
                misalign_err <= 1'b1;
            end
        end else begin
            case (state)
                ST_BOOT: begin
                    state    <= ST_RUN;
                    pc_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state    <= ST_HALT;
                        pc_valid <= 1'b0;
                        halted   <= 1'b1;
                    end else if (!stall && fetch_ready) begin
                        pc_out  <= next_seq;
                        pc_prev <= pc_out;
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state    <= ST_RUN;
                        pc_valid <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_BOOT;
                    pc_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule
